// File: rtl/aes256_stream_feeder.sv
// rtl/aes256_stream_feeder.sv - memory-to-AES-coprocessor streaming engine with status polling
module aes256_stream_feeder #(
  parameter int AW      = 16,
  parameter int CW      = 16,
  parameter int TIMEOUT = 1024
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] src_base,
  input  logic [AW-1:0] dst_base,
  input  logic [CW-1:0] num_words,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] mem_addr,
  output logic          mem_re,
  input  logic [31:0]   mem_rdata,
  output logic          mem_we,
  output logic [31:0]   mem_wdata,
  output logic [3:0]    cp_addr,
  output logic          cp_write_en,
  output logic [31:0]   cp_wdata,
  input  logic [31:0]   cp_rdata
);

  localparam int IW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] REG_CTRL = 4'd0;
  localparam logic [3:0] REG_IN   = 4'd13;
  localparam logic [3:0] REG_OUT  = 4'd14;

  typedef enum logic [3:0] {
    S_IDLE, S_CLR, S_RUN, S_POLL, S_MRD, S_PUSH, S_POP, S_STOP, S_DONE, S_ERR
  } state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] src_q, src_d;
  logic [AW-1:0] dst_q, dst_d;
  logic [CW-1:0] num_q, num_d;
  logic [CW-1:0] in_cnt_q, in_cnt_d;
  logic [CW-1:0] out_cnt_q, out_cnt_d;
  logic [IW-1:0] idle_cnt_q, idle_cnt_d;
  logic          err_q, err_d;

  logic st_in_full, st_out_empty;
  assign st_in_full   = cp_rdata[30];
  assign st_out_empty = cp_rdata[27];

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dst_q      <= '0;
      num_q      <= '0;
      in_cnt_q   <= '0;
      out_cnt_q  <= '0;
      idle_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dst_q      <= dst_d;
      num_q      <= num_d;
      in_cnt_q   <= in_cnt_d;
      out_cnt_q  <= out_cnt_d;
      idle_cnt_q <= idle_cnt_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dst_d      = dst_q;
    num_d      = num_q;
    in_cnt_d   = in_cnt_q;
    out_cnt_d  = out_cnt_q;
    idle_cnt_d = idle_cnt_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          src_d      = src_base;
          dst_d      = dst_base;
          num_d      = num_words;
          in_cnt_d   = '0;
          out_cnt_d  = '0;
          idle_cnt_d = '0;
          err_d      = 1'b0;
          if (num_words == '0) begin
            state_d = S_DONE;
          end else if (num_words[1:0] != 2'b00) begin
            // the coprocessor only ever emits whole 128-bit blocks
            state_d = S_ERR;
            err_d   = 1'b1;
          end else begin
            state_d = S_CLR;
          end
        end
      end
      S_CLR: state_d = S_RUN;
      S_RUN: state_d = S_POLL;
      S_POLL: begin
        // draining first keeps the output FIFO from ever backing up
        if (out_cnt_q == num_q) begin
          state_d = S_STOP;
        end else if (!st_out_empty) begin
          state_d = S_POP;
        end else if ((in_cnt_q < num_q) && !st_in_full) begin
          state_d = S_MRD;
        end else begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          if (idle_cnt_q == IW'(TIMEOUT - 1)) begin
            state_d = S_ERR;
            err_d   = 1'b1;
          end
        end
      end
      S_MRD: state_d = S_PUSH;
      S_PUSH: begin
        in_cnt_d   = in_cnt_q + 1'b1;
        idle_cnt_d = '0;
        state_d    = S_POLL;
      end
      S_POP: begin
        out_cnt_d  = out_cnt_q + 1'b1;
        idle_cnt_d = '0;
        state_d    = S_POLL;
      end
      S_STOP: state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      S_ERR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy        = 1'b0;
    done        = 1'b0;
    err         = err_q;
    mem_addr    = '0;
    mem_re      = 1'b0;
    mem_we      = 1'b0;
    mem_wdata   = 32'd0;
    cp_addr     = REG_CTRL;
    cp_write_en = 1'b0;
    cp_wdata    = 32'd0;
    case (state_q)
      S_CLR: begin
        busy        = 1'b1;
        cp_write_en = 1'b1;
        cp_wdata    = 32'h2;
      end
      S_RUN: begin
        busy        = 1'b1;
        cp_write_en = 1'b1;
        cp_wdata    = 32'h1;
      end
      S_POLL: busy = 1'b1;
      S_MRD: begin
        busy     = 1'b1;
        mem_re   = 1'b1;
        mem_addr = src_q + AW'(in_cnt_q);
      end
      S_PUSH: begin
        busy        = 1'b1;
        cp_addr     = REG_IN;
        cp_write_en = 1'b1;
        cp_wdata    = mem_rdata;
      end
      S_POP: begin
        busy        = 1'b1;
        cp_addr     = REG_OUT;
        cp_write_en = 1'b1;
        mem_we      = 1'b1;
        mem_addr    = dst_q + AW'(out_cnt_q);
        mem_wdata   = cp_rdata;
      end
      S_STOP: begin
        busy        = 1'b1;
        cp_write_en = 1'b1;
      end
      S_DONE: done = 1'b1;
      S_ERR:  cp_write_en = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_aes256_stream_feeder.sv
// tb/tb_aes256_stream_feeder.sv - vector-table bench with memory and XOR coprocessor models
module tb_aes256_stream_feeder;

  logic        clk;
  logic        reset;
  logic        start;
  logic [15:0] src_base, dst_base, num_words;
  logic        busy, done, err;
  logic [15:0] mem_addr;
  logic        mem_re, mem_we;
  logic [31:0] mem_rdata, mem_wdata;
  logic [3:0]  cp_addr;
  logic        cp_write_en;
  logic [31:0] cp_wdata, cp_rdata;

  aes256_stream_feeder #(.AW(16), .CW(16), .TIMEOUT(16)) dut (
    .clock(clk), .reset(reset), .start(start),
    .src_base(src_base), .dst_base(dst_base), .num_words(num_words),
    .busy(busy), .done(done), .err(err),
    .mem_addr(mem_addr), .mem_re(mem_re), .mem_rdata(mem_rdata),
    .mem_we(mem_we), .mem_wdata(mem_wdata),
    .cp_addr(cp_addr), .cp_write_en(cp_write_en), .cp_wdata(cp_wdata), .cp_rdata(cp_rdata)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] pat(input logic [15:0] a);
    return {a, a ^ 16'h5A3C};
  endfunction

  // memory: reads return a fixed address pattern, writes land in wmem
  logic [31:0] wmem [0:65535];
  always @(posedge clk) begin
    if (mem_re) mem_rdata <= pat(mem_addr);
    if (mem_we) wmem[mem_addr] <= mem_wdata;
  end

  // coprocessor: every 4 pushed words become 4 output words XOR 0xA5A5A5A5
  logic        force_full;
  logic [31:0] ififo [0:3];
  logic [31:0] ofifo [0:15];
  logic [1:0]  icnt;
  logic [4:0]  ocnt;
  logic [3:0]  ohead, wp;
  assign wp = ohead + ocnt[3:0];
  assign cp_rdata = (cp_addr == 4'd0)
                  ? {(icnt == 2'd0), force_full, 2'b00, (force_full || ocnt == 5'd0), 27'd0}
                  : (cp_addr == 4'd14) ? ofifo[ohead] : 32'd0;

  initial begin
    icnt = 2'd0;
    ocnt = 5'd0;
    ohead = 4'd0;
  end

  always @(posedge clk) begin
    if (cp_write_en) begin
      case (cp_addr)
        4'd0: if (cp_wdata[1]) begin
          icnt <= 2'd0;
          ocnt <= 5'd0;
        end
        4'd13: begin
          if (icnt == 2'd3) begin
            ofifo[wp]        <= ififo[0] ^ 32'hA5A5A5A5;
            ofifo[wp + 4'd1] <= ififo[1] ^ 32'hA5A5A5A5;
            ofifo[wp + 4'd2] <= ififo[2] ^ 32'hA5A5A5A5;
            ofifo[wp + 4'd3] <= cp_wdata ^ 32'hA5A5A5A5;
            ocnt <= ocnt + 5'd4;
            icnt <= 2'd0;
          end else begin
            ififo[icnt] <= cp_wdata;
            icnt <= icnt + 2'd1;
          end
        end
        4'd14: if (ocnt != 5'd0) begin
          ohead <= ohead + 4'd1;
          ocnt  <= ocnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_err"}, {31'd0, err}, 32'd0);
    chk({tag, "_strobes"}, {29'd0, mem_re, mem_we, cp_write_en}, 32'd0);
    chk({tag, "_cp_addr"}, {28'd0, cp_addr}, 32'd0);
    chk({tag, "_mem_addr"}, {16'd0, mem_addr}, 32'd0);
    chk({tag, "_cp_wdata"}, cp_wdata, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
  endtask

  typedef struct {
    logic [15:0] n, src, dst;
    bit          full, exp_done, exp_err;
    int          exp_push, exp_pop, exp_r0n;
    logic [11:0] exp_r0seq;
    int          exp_cyc, exp_polls;
  } vec_t;

  vec_t tbl [8];

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, npush, npop, nre, r0n, nbusy, npoll, ndone, coll, abad, mbad;
    logic [11:0] r0seq;
    logic [15:0] a;
    bit fin;
    cyc = 0; npush = 0; npop = 0; nre = 0; r0n = 0; nbusy = 0; npoll = 0;
    ndone = 0; coll = 0; abad = 0; mbad = 0; r0seq = 12'd0; fin = 1'b0;
    @(negedge clk);
    force_full = v.full;
    src_base = v.src; dst_base = v.dst; num_words = v.n; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (!fin && cyc < 400) begin
      cyc++;
      if (mem_re) begin
        a = v.src + nre[15:0];
        if (mem_addr !== a) abad++;
        nre++;
      end
      if (mem_re && mem_we) coll++;
      if (cp_write_en && cp_addr == 4'd13) npush++;
      if (cp_write_en && cp_addr == 4'd14) npop++;
      if (cp_write_en && cp_addr == 4'd0) begin
        r0seq = {r0seq[7:0], cp_wdata[3:0]};
        r0n++;
      end
      if (busy) nbusy++;
      if (busy && !cp_write_en && !mem_re && !mem_we) npoll++;
      if (done) begin
        ndone++;
        fin = 1'b1;
      end
      if (err) fin = 1'b1;
      @(negedge clk);
    end
    chk($sformatf("r%0d_finish", idx), {31'd0, fin}, 32'd1);
    chk($sformatf("r%0d_cycles", idx), cyc, v.exp_cyc);
    chk($sformatf("r%0d_busy_cycles", idx), nbusy, v.exp_cyc - 1);
    chk($sformatf("r%0d_polls", idx), npoll, v.exp_polls);
    chk($sformatf("r%0d_push", idx), npush, v.exp_push);
    chk($sformatf("r%0d_pop", idx), npop, v.exp_pop);
    chk($sformatf("r%0d_reads", idx), nre, v.exp_push);
    chk($sformatf("r%0d_rd_addr", idx), abad, 0);
    chk($sformatf("r%0d_collide", idx), coll, 0);
    chk($sformatf("r%0d_r0_count", idx), r0n, v.exp_r0n);
    chk($sformatf("r%0d_r0_seq", idx), {20'd0, r0seq}, {20'd0, v.exp_r0seq});
    chk($sformatf("r%0d_done_pulses", idx), ndone, {31'd0, v.exp_done});
    chk($sformatf("r%0d_done_after", idx), {31'd0, done}, 32'd0);
    chk($sformatf("r%0d_busy_after", idx), {31'd0, busy}, 32'd0);
    chk($sformatf("r%0d_err_sticky", idx), {31'd0, err}, {31'd0, v.exp_err});
    for (int i = 0; i < v.exp_pop; i++) begin
      a = v.dst + i[15:0];
      if (wmem[a] !== (pat(v.src + i[15:0]) ^ 32'hA5A5A5A5)) mbad++;
    end
    chk($sformatf("r%0d_mem_data", idx), mbad, 0);
    force_full = 1'b0;
  endtask

  initial begin
    int cyc, np, nre;
    bit stray;
    tbl[0] = '{16'd8,  16'h0100, 16'h0200, 1'b0, 1'b1, 1'b0, 8,  8,  3, 12'h210, 45, 17};
    tbl[1] = '{16'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0,  0,  0, 12'h000, 1,  0};
    tbl[2] = '{16'd6,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0,  0,  1, 12'h000, 1,  0};
    tbl[3] = '{16'd4,  16'h0010, 16'h0020, 1'b1, 1'b0, 1'b1, 0,  0,  3, 12'h210, 19, 16};
    tbl[4] = '{16'd0,  16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0, 0,  0,  0, 12'h000, 1,  0};
    tbl[5] = '{16'd4,  16'hFFFE, 16'h0300, 1'b0, 1'b1, 1'b0, 4,  4,  3, 12'h210, 25, 9};
    tbl[6] = '{16'd12, 16'h0400, 16'h0600, 1'b0, 1'b1, 1'b0, 12, 12, 3, 12'h210, 65, 25};
    tbl[7] = '{16'd5,  16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1, 0,  0,  1, 12'h000, 1,  0};

    reset = 1'b0; start = 1'b0; force_full = 1'b0;
    src_base = 16'd0; dst_base = 16'd0; num_words = 16'd0;
    repeat (2) @(negedge clk);
    chk_quiet("rst_hold");
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("rst_release");

    for (int i = 0; i < 8; i++) run_vec(i, tbl[i]);

    // wrap-around reads, a stray start while busy, then reset after two pushes
    @(negedge clk);
    src_base = 16'hFFFE; dst_base = 16'h0700; num_words = 16'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; np = 0; nre = 0; stray = 1'b0;
    while (np < 2 && cyc < 200) begin
      start = 1'b0;
      if (mem_re) begin
        chk($sformatf("abort_rd_addr%0d", nre), {16'd0, mem_addr},
            (nre == 0) ? 32'h0000FFFE : 32'h0000FFFF);
        nre++;
      end
      if (cp_write_en && cp_addr == 4'd13) np++;
      if (np == 1 && !stray) begin
        start = 1'b1;
        num_words = 16'd6;
        stray = 1'b1;
      end
      if (np < 2) begin
        @(negedge clk);
        cyc++;
      end
    end
    start = 1'b0;
    chk("abort_pushes", np, 2);
    chk("abort_reads", nre, 2);
    chk("abort_stray_start_err", {31'd0, err}, 32'd0);
    chk("abort_busy_before", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    @(negedge clk);
    chk_quiet("abort_rst");
    reset = 1'b1;
    @(negedge clk);
    chk_quiet("abort_idle");

    @(negedge clk);
    num_words = 16'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("post_rst_done", {31'd0, done}, 32'd1);
    chk("post_rst_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("post_rst_done_clear", {31'd0, done}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
